// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply / divide unit with HI/LO registers.
// One radix-2 step per cycle; every MULT/MULTU/DIV/DIVU takes a fixed
// 35 cycles from first presentation until Busy drops.
// Build option: define MULDIV_SIGNED_EN to give MULT/DIV signed semantics;
// without it they behave exactly like MULTU/DIVU.
//
//   state | meaning
//   IDLE  | waiting; MTHI/MTLO/MFHI/MFLO serviced here, mul/div op accepted
//   RUN   | 32 shift-add (mul) or restoring-subtract (div) steps on magnitudes
//   FIX   | sign correction / divide-by-zero override; HI/LO written on exit
//   DONE  | result visible, Busy low so the CPU moves on; always back to IDLE
module muldiv (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  output logic [31:0] HiLoData,
  output logic        Busy
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;

  // latched operation context
  logic        is_div;
  logic        neg_a, neg_b;
  logic [31:0] mop;         // multiplicand magnitude or divisor magnitude
  logic [31:0] a_raw;       // original dividend, returned in HI on divide-by-zero
  logic [32:0] acc_hi;      // partial product high half / partial remainder
  logic [31:0] acc_lo;      // multiplier shifting out / quotient shifting in

  // decode
  logic        is_r;
  logic [5:0]  funct;
  logic        op_mult, op_multu, op_div, op_divu, op_start, op_isdiv, signed_op;
  logic        op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic [31:0] mag_a_in, mag_b_in;
  logic        unused_ins;

  assign is_r      = (Ins[31:26] == 6'h00);
  assign funct     = Ins[5:0];
  assign op_mult   = is_r && (funct == F_MULT);
  assign op_multu  = is_r && (funct == F_MULTU);
  assign op_div    = is_r && (funct == F_DIV);
  assign op_divu   = is_r && (funct == F_DIVU);
  assign op_mfhi   = is_r && (funct == F_MFHI);
  assign op_mflo   = is_r && (funct == F_MFLO);
  assign op_mthi   = is_r && (funct == F_MTHI);
  assign op_mtlo   = is_r && (funct == F_MTLO);
  assign op_start  = op_mult || op_multu || op_div || op_divu;
  assign op_isdiv  = op_div || op_divu;
  assign unused_ins = ^Ins[25:6];

`ifdef MULDIV_SIGNED_EN
  assign signed_op = op_mult || op_div;
`else
  assign signed_op = 1'b0;
`endif

  assign mag_a_in = (signed_op && Rdata1[31]) ? (~Rdata1 + 32'd1) : Rdata1;
  assign mag_b_in = (signed_op && Rdata2[31]) ? (~Rdata2 + 32'd1) : Rdata2;

  // one iteration step of either algorithm
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_trial;

  assign mul_sum   = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, mop} : 33'd0);
  assign div_shift = {acc_hi[31:0], acc_lo[31]};
  assign div_trial = div_shift - {1'b0, mop};

  // sign correction applied in FIX
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;

  assign prod     = {acc_hi[31:0], acc_lo};
  assign prod_fix = (neg_a ^ neg_b) ? (~prod + 64'd1) : prod;
  assign quo_fix  = (neg_a ^ neg_b) ? (~acc_lo + 32'd1) : acc_lo;
  assign rem_fix  = neg_a ? (~acc_hi[31:0] + 32'd1) : acc_hi[31:0];

  // select the value written to HI/LO when leaving FIX
  always_comb begin
    fix_hi = prod_fix[63:32];
    fix_lo = prod_fix[31:0];
    if (is_div) begin
      if (mop == 32'd0) begin
        fix_hi = a_raw;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: stall request and HI/LO read port, both forced low in reset
  always_comb begin
    Busy     = 1'b0;
    HiLoData = 32'd0;
    if (!RST) begin
      Busy = ((state == IDLE) && op_start) || (state == RUN) || (state == FIX);
      if (op_mfhi)      HiLoData = hi;
      else if (op_mflo) HiLoData = lo;
    end
  end

  // step counter: cleared on acceptance, advanced once per RUN cycle
  always_ff @(posedge CLK) begin
    if (RST)                                 cnt <= 5'd0;
    else if ((state == IDLE) && op_start)    cnt <= 5'd0;
    else if (state == RUN)                   cnt <= cnt + 5'd1;
  end

  // operand latch and iteration datapath
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if ((state == IDLE) && op_start) begin
        is_div <= op_isdiv;
        neg_a  <= signed_op && Rdata1[31];
        neg_b  <= signed_op && Rdata2[31];
        a_raw  <= Rdata1;
        acc_hi <= 33'd0;
        if (op_isdiv) begin
          mop    <= mag_b_in;
          acc_lo <= mag_a_in;
        end else begin
          mop    <= mag_a_in;
          acc_lo <= mag_b_in;
        end
      end else if (state == RUN) begin
        if (is_div) begin
          if (!div_trial[32]) begin
            acc_hi <= div_trial;
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
        end else begin
          acc_hi <= {1'b0, mul_sum[32:1]};
          acc_lo <= {mul_sum[0], acc_lo[31:1]};
        end
      end
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == IDLE) begin
      if (op_mthi) hi <= Rdata1;
      if (op_mtlo) lo <= Rdata1;
    end
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameters: none; width fixed at 32 bits; the iteration count is fixed at 32.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 Ins  input  32  current instruction; opcode Ins[31:26], funct Ins[5:0].
REQ-005 Rdata1  input  32  rs operand: multiplicand or dividend; source for MTHI/MTLO.
REQ-006 Rdata2  input  32  rt operand: multiplier or divisor.
REQ-007 HiLoData  output  32  HI for MFHI, LO for MFLO, else 32'd0; combinational; feeds the execute-stage result mux ahead of data memory.
REQ-008 Busy  output  1  stall request; the CPU SHALL hold PC and Ins while high.

Function
REQ-009 Decode SHALL apply only when opcode=6'h00, using these functs:
- MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B
- MFHI=6'h10, MTHI=6'h11, MFLO=6'h12, MTLO=6'h13
REQ-010 States SHALL be IDLE, RUN, FIX, DONE.
REQ-011 IDLE with a mul/div op present: Busy=1 combinationally; the edge latches operand magnitudes and signs, clears the counter, and moves to RUN.
REQ-012 RUN: one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes); after 32 steps, move to FIX; Busy=1.
REQ-013 FIX: apply sign correction; write HI/LO at the edge leaving FIX; move to DONE; Busy=1.
REQ-014 DONE: Busy=0 so the CPU advances; the still-present op SHALL NOT restart; the next edge moves to IDLE.
REQ-015 Fixed timing per op:
- 35 cycles from first presentation to PC advance (1 IDLE, 32 RUN, 1 FIX, 1 DONE).
- HI/LO new values visible from the DONE cycle.
REQ-016 Multiply result: HI=product[63:32], LO=product[31:0].
- Signed product is negated in FIX when the operand signs differ.
REQ-017 Divide result: LO=quotient, HI=remainder.
- Quotient sign = sign XOR of the operands.
- Remainder sign = dividend sign.
REQ-018 Divide by zero (signed and unsigned): LO=32'hFFFFFFFF, HI=Rdata1; same latency.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=32'd0.
REQ-020 MTHI/MTLO in IDLE: write Rdata1 to HI/LO at the edge; Busy=0; single cycle.
REQ-021 MFHI/MFLO in IDLE: Busy=0; HiLoData reflects the registered HI/LO.
REQ-022 Any non-mul/div instruction in IDLE: Busy=0; no state change.
REQ-023 The operand latch SHALL make results independent of Rdata1/Rdata2 changes after acceptance.

Reset
REQ-024 While RST=1:
- HI=LO=32'd0, state=IDLE, counter=0.
- Busy=0 and HiLoData=32'd0 regardless of Ins.
REQ-025 RST asserted mid-operation (RUN/FIX/DONE) SHALL abort without writing HI/LO.
- After RST deasserts, a still-present op restarts from IDLE with full latency.

Configuration
REQ-026 Macro MULDIV_SIGNED_EN:
- Defined: MULT/DIV use signed semantics per REQ-016..019.
- Undefined: MULT/DIV decode as MULTU/DIVU; FIX applies no correction; latency unchanged at 35 cycles.

Verification
REQ-027 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF:
- Busy high for 34 cycles, low on the 35th.
- HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-028 DIV with macro defined, -7 / 2: LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- Without the macro: LO=32'h7FFFFFFC, HI=32'h00000001.
REQ-029 DIVU 32'h12345678 / 0: LO=32'hFFFFFFFF, HI=32'h12345678, latency 35 cycles.
REQ-030 MTLO 32'hA5A5A5A5 then MFLO: Busy never high; HiLoData=32'hA5A5A5A5 on the MFLO cycle.
REQ-031 Reset at RUN cycle 10 of MULT 3x4:
- HI=LO=0 after reset.
- Held op reruns and yields LO=12, HI=0.
REQ-032 Signed 32'h80000000 / -1 (macro defined): LO=32'h80000000, HI=0; no restart seen during DONE.
